spi_server: RTL and testbench



---
 rtl/spi_server_if.sv | 50 +++++
 rtl/spi_server.sv | 173 +++++++++++++++++
 tb/tb_spi_server.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_server_if.sv
// Command, write-data and read-data bundle between a host and spi_server.
//
// Handshake rules:
//   cmd:     a command is taken on the clk edge where cmd_valid && cmd_ready
//            (and the client is idle); cmd_ready is high only while the server is idle.
//   wr_data: a word is taken on the clk edge where wr_data_valid && wr_data_ready.
//            wr_data_ready is asserted only while wr_data_valid is high, so it
//            marks exactly the consuming cycle. The host holds wr_data stable
//            while wr_data_valid is high.
//   rd_data: no back-pressure; rd_data_valid is a one-cycle pulse and rd_data
//            holds the last received word.
interface spi_server_if #(
    parameter int MESSAGE_BIT_WIDTH       = 32,
    parameter int CODE_BIT_WIDTH          = 4,
    parameter int START_ADDRESS_BIT_WIDTH = 16
);
    localparam int NumTransactionsBitWidth =
        MESSAGE_BIT_WIDTH - CODE_BIT_WIDTH - START_ADDRESS_BIT_WIDTH - 1;

    logic                               cmd_valid;
    logic                               cmd_ready;
    logic                               cmd_read;
    logic [CODE_BIT_WIDTH-1:0]          cmd_code;
    logic [START_ADDRESS_BIT_WIDTH-1:0] cmd_address;
    logic [NumTransactionsBitWidth-1:0] cmd_count;
    logic [MESSAGE_BIT_WIDTH-1:0]       wr_data;
    logic                               wr_data_valid;
    logic                               wr_data_ready;
    logic [MESSAGE_BIT_WIDTH-1:0]       rd_data;
    logic                               rd_data_valid;
    logic                               busy;
    logic                               done;
    logic                               cmd_error;

    // Host side: issues commands and supplies write words.
    modport master (
        output cmd_valid, cmd_read, cmd_code, cmd_address, cmd_count,
        output wr_data, wr_data_valid,
        input  cmd_ready, wr_data_ready, rd_data, rd_data_valid,
        input  busy, done, cmd_error
    );

    // Server side: spi_server.
    modport slave (
        input  cmd_valid, cmd_read, cmd_code, cmd_address, cmd_count,
        input  wr_data, wr_data_valid,
        output cmd_ready, wr_data_ready, rd_data, rd_data_valid,
        output busy, done, cmd_error
    );
endinterface

// File: rtl/spi_server.sv
// SPI master: sends one instruction word {read, code, address, count} then
// count data words. Writes stream wr_data out on MOSI (stalling with SCK low
// if no word is ready); reads shift MISO in and present each word on rd_data.
module spi_server #(
    parameter int MESSAGE_BIT_WIDTH       = 32,
    parameter int CODE_BIT_WIDTH          = 4,
    parameter int START_ADDRESS_BIT_WIDTH = 16,
    parameter int CLK_DIV                 = 2
) (
    input  logic         clk,
    input  logic         rst_async_n,
    output logic         SCK,
    output logic         MOSI,
    input  logic         MISO,
    input  logic         client_idle,
    spi_server_if.slave  bus,
    output logic [1:0]   state_dbg
);
    localparam int NumTransactionsBitWidth =
        MESSAGE_BIT_WIDTH - CODE_BIT_WIDTH - START_ADDRESS_BIT_WIDTH - 1;
    localparam int WordW  = NumTransactionsBitWidth + 1;
    localparam int BitW   = $clog2(MESSAGE_BIT_WIDTH);
    localparam int PhaseW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int W      = MESSAGE_BIT_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DATA = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t                             state_q, state_next;
    logic                               sck_q;
    logic [PhaseW-1:0]                  phase_q;
    logic [BitW-1:0]                    bit_q;
    logic [WordW-1:0]                   word_q;   // 0 = instruction, 1..count = data
    logic [NumTransactionsBitWidth-1:0] count_q;
    logic                               read_q;
    logic [W-1:0]                       tx_q;     // MSB is the bit on MOSI
    logic [W-1:0]                       rx_q;
    logic [W-1:0]                       rd_data_q;
    logic                               rd_valid_q;
    logic                               cmd_error_q;
    logic                               wr_take;

    logic [W-1:0] instr;
    logic         cmd_hit, accept, reject;
    logic         phase_end, rise, fall, bit_last, word_end, last_word, need_wr;

    assign instr     = {bus.cmd_read, bus.cmd_code, bus.cmd_address, bus.cmd_count};
    assign cmd_hit   = (state_q == IDLE) && bus.cmd_valid && client_idle;
    assign accept    = cmd_hit && (bus.cmd_count != '0);
    assign reject    = cmd_hit && (bus.cmd_count == '0);
    assign phase_end = (phase_q == PhaseW'(CLK_DIV - 1));
    assign rise      = (state_q == SHIFT) && !sck_q && phase_end;
    assign fall      = (state_q == SHIFT) && sck_q && phase_end;
    assign bit_last  = (bit_q == BitW'(W - 1));
    assign word_end  = fall && bit_last;
    assign last_word = (word_q == {1'b0, count_q});
    // The next word is a write data word and needs wr_data now.
    assign need_wr   = word_end && !last_word && !read_q;

    // Next-state and write-data handshake decode.
    always_comb begin
        state_next = state_q;
        wr_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_next = SHIFT;
            end
            SHIFT: begin
                if (need_wr) wr_take = bus.wr_data_valid;
                if (word_end) begin
                    if (last_word)                          state_next = FINISH;
                    else if (need_wr && !bus.wr_data_valid) state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                wr_take = bus.wr_data_valid;
                if (bus.wr_data_valid) state_next = SHIFT;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) state_q <= IDLE;
        else              state_q <= state_next;
    end

    // SCK timing, bit/word counters and the shift datapath.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            sck_q       <= 1'b0;
            phase_q     <= '0;
            bit_q       <= '0;
            word_q      <= '0;
            count_q     <= '0;
            read_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            rd_valid_q  <= 1'b0;
            cmd_error_q <= reject;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        read_q  <= bus.cmd_read;
                        count_q <= bus.cmd_count;
                        tx_q    <= instr;
                        rx_q    <= '0;
                        sck_q   <= 1'b0;
                        phase_q <= '0;
                        bit_q   <= '0;
                        word_q  <= '0;
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        phase_q <= '0;
                        sck_q   <= ~sck_q;
                    end else begin
                        phase_q <= phase_q + PhaseW'(1);
                    end
                    if (rise) rx_q <= {rx_q[W-2:0], MISO};
                    if (fall) begin
                        if (bit_last) begin
                            bit_q  <= '0;
                            word_q <= word_q + WordW'(1);
                            if (read_q && (word_q != '0)) begin
                                rd_data_q  <= rx_q;
                                rd_valid_q <= 1'b1;
                            end
                            // Reads and the idle line after the last word send zeros.
                            if (last_word || read_q)    tx_q <= '0;
                            else if (bus.wr_data_valid) tx_q <= bus.wr_data;
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                            tx_q  <= {tx_q[W-2:0], 1'b0};
                        end
                    end
                end
                WAIT_DATA: begin
                    // SCK is already low and MOSI holds; restart the low phase on resume.
                    if (bus.wr_data_valid) begin
                        tx_q    <= bus.wr_data;
                        phase_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SCK               = sck_q;
    assign MOSI              = tx_q[W-1];
    assign state_dbg         = state_q;
    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == FINISH);
    assign bus.cmd_error     = cmd_error_q;
    assign bus.wr_data_ready = wr_take;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
endmodule

// File: tb/tb_spi_server.sv
// Bench for spi_server (32-bit words, CLK_DIV = 2) with a behavioural SPI client.
module tb_spi_server;
    logic       clk = 1'b0;
    logic       rst_async_n;
    logic       SCK, MOSI, MISO, client_idle;
    logic [1:0] state_dbg;

    spi_server_if bus ();

    spi_server #(.CLK_DIV(2)) dut (
        .clk         (clk),
        .rst_async_n (rst_async_n),
        .SCK         (SCK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .client_idle (client_idle),
        .bus         (bus),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_mosi_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] model_mem[logic [15:0]];
    logic [31:0] cl_mem[logic [15:0]];

    int busy_cycles, sck_rises, mosi_viol, wait_cycles, wait_viol;
    int rdy_count, err_count, done_count, done_at;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_counters();
        busy_cycles = 0; sck_rises = 0; mosi_viol = 0; wait_cycles = 0; wait_viol = 0;
        rdy_count = 0; err_count = 0; done_count = 0; done_at = 0;
    endtask

    // ---------------- write-data feeder ----------------
    bit take;
    always begin
        @(negedge clk);
        take = bus.wr_data_valid && bus.wr_data_ready;
        @(posedge clk);
        #1;
        if (take && wr_q.size() > 0) void'(wr_q.pop_front());
        bus.wr_data       = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
        bus.wr_data_valid = (wr_q.size() > 0);
    end

    // ---------------- behavioural SPI client ----------------
    int          cl_bits = 0;
    logic        cl_read = 1'b0;
    logic [15:0] cl_addr = '0;
    logic [31:0] cl_shift = '0;
    logic [31:0] cl_word;
    logic        cl_sck_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.busy !== 1'b1) begin
            cl_bits = 0;
            cl_read = 1'b0;
            MISO    = 1'b0;
        end else if (SCK && !cl_sck_prev) begin
            cl_shift = {cl_shift[30:0], MOSI};
            cl_bits++;
            if (cl_bits % 32 == 0) begin
                if (exp_mosi_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mosi_extra actual=%0h required=none", cl_shift);
                end else begin
                    check("mosi_word", cl_shift, exp_mosi_q.pop_front());
                end
                if (cl_bits == 32) begin
                    cl_read = cl_shift[31];
                    cl_addr = cl_shift[26:11];
                end else if (!cl_read) begin
                    cl_mem[cl_addr + 16'(cl_bits / 32 - 2)] = cl_shift;
                end
            end
        end else if (!SCK && cl_sck_prev) begin
            if (cl_read && cl_bits >= 32) begin
                cl_word = cl_mem[cl_addr + 16'(cl_bits / 32 - 1)];
                MISO    = cl_word[31 - (cl_bits % 32)];
            end else begin
                MISO = 1'b0;
            end
        end
        cl_sck_prev = SCK;
    end

    // ---------------- output monitor ----------------
    logic mon_sck_prev = 1'b0;
    logic mon_mosi_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cycles++;
        if (SCK && !mon_sck_prev) sck_rises++;
        if (SCK && (MOSI !== mon_mosi_prev)) mosi_viol++;
        if (state_dbg == 2'd2) begin
            wait_cycles++;
            if (SCK) wait_viol++;
        end
        if (bus.wr_data_ready === 1'b1) rdy_count++;
        if (bus.cmd_error === 1'b1) err_count++;
        if (bus.done === 1'b1) begin
            done_count++;
            done_at = busy_cycles;
        end
        if (bus.rd_data_valid === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_extra actual=%0h required=none", bus.rd_data);
            end else begin
                check("rd_data", bus.rd_data, exp_rd_q.pop_front());
            end
        end
        mon_sck_prev  = SCK;
        mon_mosi_prev = MOSI;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic rd, input logic [3:0] code,
                             input logic [15:0] addr, input logic [10:0] count);
        @(posedge clk); #1;
        bus.cmd_read = rd; bus.cmd_code = code; bus.cmd_address = addr;
        bus.cmd_count = count; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_count == 0 && n < limit) begin
            @(negedge clk); #2;
            n++;
        end
        if (done_count == 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=%0d required=<%0d cycles", n, limit);
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    typedef struct {
        logic            rd;
        logic [3:0]      code;
        logic [15:0]     addr;
        logic [10:0]     count;
        logic [3:0][31:0] words;
        logic [31:0]     exp_instr;
        int              exp_cycles;
    } vec_t;

    task automatic run_entry(input vec_t v, input int idx);
        clear_counters();
        exp_mosi_q.push_back(v.exp_instr);
        for (int i = 0; i < int'(v.count); i++) begin
            if (v.rd) begin
                exp_mosi_q.push_back(32'h0);
                exp_rd_q.push_back(model_mem[v.addr + 16'(i)]);
            end else begin
                wr_q.push_back(v.words[i]);
                exp_mosi_q.push_back(v.words[i]);
                model_mem[v.addr + 16'(i)] = v.words[i];
            end
        end
        issue_cmd(v.rd, v.code, v.addr, v.count);
        client_idle = 1'b0;  // must not disturb a running transaction
        wait_done(v.exp_cycles + 50);
        client_idle = 1'b1;
        $display("vector %0d done at busy cycle %0d", idx, done_at);
        check("done_cycle", done_at, v.exp_cycles);
        check("done_pulses", done_count, 1);
        check("sck_pulses", sck_rises, (v.count + 1) * 32);
        check("mosi_left", exp_mosi_q.size(), 0);
        check("rd_left", exp_rd_q.size(), 0);
        check("wr_ready_pulses", rdy_count, v.rd ? 0 : int'(v.count));
        check("mosi_high_change", mosi_viol, 0);
        check("idle_after", state_dbg, 2'd0);
    endtask

    vec_t vecs[6];

    // ---------------- test sequence ----------------
    initial begin
        int n;
        // Instruction layout: [31] read, [30:27] code, [26:11] address, [10:0] count.
        vecs[0] = '{1'b0, 4'h0, 16'h0010, 11'd2, {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF},
                    32'h00008002, 385};
        vecs[1] = '{1'b1, 4'h0, 16'h0100, 11'd3, '0, 32'h80080003, 513};
        vecs[2] = '{1'b0, 4'hF, 16'hFFFF, 11'd1, {96'h0, 32'h80000001}, 32'h7FFFF801, 257};
        vecs[3] = '{1'b1, 4'h5, 16'h0010, 11'd1, '0, 32'hA8008001, 257};
        vecs[4] = '{1'b0, 4'h0, 16'h0200, 11'd4, '0, 32'h00100004, 641};
        vecs[5] = '{1'b1, 4'h0, 16'h0200, 11'd4, '0, 32'h80100004, 641};
        for (int i = 0; i < 4; i++) vecs[4].words[i] = $urandom_range(32'hFFFFFFFF, 0);
        // Client preloaded contents for the read vector.
        cl_mem[16'h0100] = 32'hA5A5A5A5; model_mem[16'h0100] = 32'hA5A5A5A5;
        cl_mem[16'h0101] = 32'h0F0F0F0F; model_mem[16'h0101] = 32'h0F0F0F0F;
        cl_mem[16'h0102] = 32'hFFFF0000; model_mem[16'h0102] = 32'hFFFF0000;

        rst_async_n = 1'b1; client_idle = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_code = '0;
        bus.cmd_address = '0; bus.cmd_count = '0;
        #3 rst_async_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_sck", SCK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_valid", bus.rd_data_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_cmd_error", bus.cmd_error, 0);
        check("rst_wr_ready", bus.wr_data_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_state", state_dbg, 2'd0);
        @(posedge clk); #1 rst_async_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-count command is rejected with a single error pulse.
        clear_counters();
        issue_cmd(1'b0, 4'h3, 16'h1234, 11'd0);
        repeat (4) @(negedge clk);
        #2;
        check("reject_error_pulses", err_count, 1);
        check("reject_sck", sck_rises, 0);
        check("reject_busy", busy_cycles, 0);

        // Client not idle: command held pending, nothing starts.
        clear_counters();
        @(posedge clk); #1;
        client_idle = 1'b0;
        bus.cmd_read = 1'b0; bus.cmd_count = 11'd3; bus.cmd_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("noidle_cmd_ready", bus.cmd_ready, 1);
        check("noidle_busy", busy_cycles, 0);
        check("noidle_sck", sck_rises, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; client_idle = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during word 1 bit 10 of a maximum-count write.
        clear_counters();
        wr_q.push_back(32'hCAFEF00D); wr_q.push_back(32'h0BADBEEF);
        exp_mosi_q.push_back(32'h000007FF);
        issue_cmd(1'b0, 4'h0, 16'h0000, 11'h7FF);
        n = 0;
        while (cl_bits < 42 && n < 1000) begin
            @(negedge clk); #2;
            n++;
        end
        check("reset_reached_bit", cl_bits, 42);
        rst_async_n = 1'b0;
        #1;
        check("midrst_sck", SCK, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_state", state_dbg, 2'd0);
        sck_rises = 0;
        repeat (3) @(negedge clk);
        #2 rst_async_n = 1'b1;
        wr_q.delete();
        repeat (4) @(negedge clk);
        #2;
        check("midrst_done", done_count, 0);
        check("midrst_sck_after", sck_rises, 0);
        check("midrst_instr_seen", exp_mosi_q.size(), 0);
        exp_mosi_q.delete();

        // Table: writes, reads, write-then-read loopback.
        for (int i = 0; i < 6; i++) run_entry(vecs[i], i);

        // Stall: word 2 arrives only after 20 cycles in WAIT_DATA.
        clear_counters();
        wr_q.push_back(32'h11112222);
        exp_mosi_q.push_back(32'h00180002);
        exp_mosi_q.push_back(32'h11112222);
        exp_mosi_q.push_back(32'h33334444);
        issue_cmd(1'b0, 4'h0, 16'h0300, 11'd2);
        n = 0;
        while (wait_cycles < 19 && n < 1000) begin
            @(negedge clk); #2;
            n++;
        end
        wr_q.push_back(32'h33334444);
        wait_done(600);
        check("stall_wait_cycles", wait_cycles, 20);
        check("stall_sck_low", wait_viol, 0);
        check("stall_done_cycle", done_at, 405);
        check("stall_sck_pulses", sck_rises, 96);
        check("stall_wr_ready", rdy_count, 2);
        check("stall_mosi_left", exp_mosi_q.size(), 0);
        check("stall_mosi_high_change", mosi_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
